// File: rtl/miner_pkg.sv
// Shared widths and FSM state encoding for the mining job sequencer.
package miner_pkg;

    localparam int HEADER_W  = 608;
    localparam int NONCE_W   = 32;
    localparam int HASH_W    = 256;
    localparam int CORE_IN_W = HEADER_W + NONCE_W;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_DRAIN = 3'd2,
        S_FOUND = 3'd3,
        S_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/inflight_fifo.sv
// First-word-fall-through FIFO holding the nonces issued to the hash core but not yet
// returned. Push and pop in the same cycle are legal even when full.
module inflight_fifo
    import miner_pkg::*;
#(
    parameter int WIDTH = NONCE_W,
    parameter int DEPTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem[rd_ptr_q];

    // NOTE: storage has no reset; the count and pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wdata_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CW'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

endmodule

// File: rtl/nonce_scheduler.sv
// Drives the hash core for one mining job: sweeps the nonce range one candidate per cycle,
// maps in-order core results back to nonces and reports the first nonce meeting target.
module nonce_scheduler
    import miner_pkg::*;
#(
    parameter int MAX_INFLIGHT = 32,
    parameter int CNT_W        = 48
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 stop,
    input  logic [HEADER_W-1:0]  header,
    input  logic [HASH_W-1:0]    target,
    input  logic [NONCE_W-1:0]   nonce_base,
    input  logic [NONCE_W-1:0]   nonce_limit,
    output logic [CORE_IN_W-1:0] core_in,
    output logic                 core_read,
    output logic [HASH_W-1:0]    core_target,
    input  logic                 core_out,
    input  logic                 core_write,
    output logic                 busy,
    output logic                 found,
    output logic [NONCE_W-1:0]   found_nonce,
    output logic                 done,
    output logic                 aborted,
    output logic                 err,
    output logic [CNT_W-1:0]     hash_count
);

    state_e              state_q, state_d;
    logic [HEADER_W-1:0] header_q, header_d;
    logic [HASH_W-1:0]   target_q, target_d;
    logic [NONCE_W-1:0]  limit_q, limit_d;
    logic [NONCE_W-1:0]  nonce_q, nonce_d;
    logic [NONCE_W-1:0]  found_nonce_q, found_nonce_d;
    logic                hit_q, hit_d;
    logic                abort_q, abort_d;
    logic                aborted_q, aborted_d;
    logic                err_q, err_d;
    logic [CNT_W-1:0]    hash_count_q, hash_count_d;

    logic                fifo_full, fifo_empty;
    logic [NONCE_W-1:0]  fifo_rdata;
    logic                pop, hit_now, issue;

    assign pop     = core_write && !fifo_empty;
    assign hit_now = pop && core_out && !hit_q && (state_q == S_RUN || state_q == S_DRAIN);
    // A freshly seen hit blocks the candidate that would otherwise go out this cycle.
    assign issue   = (state_q == S_RUN) && (!fifo_full || pop) && !hit_now;

    inflight_fifo #(
        .WIDTH (NONCE_W),
        .DEPTH (MAX_INFLIGHT)
    ) u_inflight_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (issue),
        .pop_i   (pop),
        .wdata_i (nonce_q),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        // NOTE: every _d takes its hold value first so no path through this block infers a latch.
        state_d       = state_q;
        header_d      = header_q;
        target_d      = target_q;
        limit_d       = limit_q;
        nonce_d       = nonce_q;
        found_nonce_d = found_nonce_q;
        hit_d         = hit_q;
        abort_d       = abort_q;
        aborted_d     = aborted_q;
        err_d         = err_q | (core_write & fifo_empty);
        hash_count_d  = hash_count_q;

        if (pop && hash_count_q != '1) begin
            hash_count_d = hash_count_q + CNT_W'(1);
        end
        if (hit_now) begin
            hit_d         = 1'b1;
            found_nonce_d = fifo_rdata;
        end
        if (issue) begin
            nonce_d = nonce_q + NONCE_W'(1);
        end

        case (state_q)
            S_IDLE, S_FOUND, S_DONE: begin
                if (start) begin
                    header_d      = header;
                    target_d      = target;
                    limit_d       = nonce_limit;
                    nonce_d       = nonce_base;
                    found_nonce_d = '0;
                    hit_d         = 1'b0;
                    abort_d       = 1'b0;
                    aborted_d     = 1'b0;
                    hash_count_d  = '0;
                    state_d       = S_RUN;
                end
            end
            S_RUN: begin
                // Hit and stop together: the hit wins and the job ends as found.
                if (stop && !hit_now) begin
                    abort_d = 1'b1;
                end
                if (hit_now || stop || (issue && nonce_q == limit_q)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (fifo_empty && !core_write) begin
                    if (hit_q) begin
                        state_d = S_FOUND;
                    end else if (abort_q) begin
                        state_d   = S_IDLE;
                        aborted_d = 1'b1;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            header_q      <= '0;
            target_q      <= '0;
            limit_q       <= '0;
            nonce_q       <= '0;
            found_nonce_q <= '0;
            hit_q         <= 1'b0;
            abort_q       <= 1'b0;
            aborted_q     <= 1'b0;
            err_q         <= 1'b0;
            hash_count_q  <= '0;
        end else begin
            state_q       <= state_d;
            header_q      <= header_d;
            target_q      <= target_d;
            limit_q       <= limit_d;
            nonce_q       <= nonce_d;
            found_nonce_q <= found_nonce_d;
            hit_q         <= hit_d;
            abort_q       <= abort_d;
            aborted_q     <= aborted_d;
            err_q         <= err_d;
            hash_count_q  <= hash_count_d;
        end
    end

    assign core_in     = {header_q, nonce_q};
    assign core_read   = issue;
    assign core_target = target_q;
    assign busy        = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign found       = (state_q == S_FOUND);
    assign done        = (state_q == S_DONE);
    assign found_nonce = found_nonce_q;
    assign aborted     = aborted_q;
    assign err         = err_q;
    assign hash_count  = hash_count_q;

endmodule

// File: tb/tb_nonce_scheduler.sv
// Self-checking bench: a fixed-latency core model plus a job-level reference model checked
// every cycle, with directed jobs whose end results are pinned by literal values.
module tb_nonce_scheduler;

    localparam int MAXI = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic [607:0] header = '0;
    logic [255:0] target = '0;
    logic [31:0]  nonce_base = '0;
    logic [31:0]  nonce_limit = '0;
    logic [639:0] core_in;
    logic         core_read;
    logic [255:0] core_target;
    logic         core_out = 1'b0;
    logic         core_write = 1'b0;
    logic         busy, found, done, aborted, err;
    logic [31:0]  found_nonce;
    logic [47:0]  hash_count;

    nonce_scheduler #(.MAX_INFLIGHT(MAXI), .CNT_W(48)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .header(header), .target(target),
        .nonce_base(nonce_base), .nonce_limit(nonce_limit), .core_in(core_in),
        .core_read(core_read), .core_target(core_target), .core_out(core_out),
        .core_write(core_write), .busy(busy), .found(found), .found_nonce(found_nonce),
        .done(done), .aborted(aborted), .err(err), .hash_count(hash_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Core model: fixed latency, in-order results, hit iff nonce is in hit_set.
    typedef struct {
        logic [31:0] nonce;
        int          due;
    } flight_t;

    flight_t     pipe[$];
    logic [31:0] hit_set[$];
    int          lat = 10;
    logic        inject_stray = 1'b0;

    function automatic logic in_set(input logic [31:0] n);
        foreach (hit_set[i]) if (hit_set[i] == n) return 1'b1;
        return 1'b0;
    endfunction

    // Job-level reference model.
    typedef enum {M_IDLE, M_RUN, M_DRAIN, M_FOUND, M_DONE} mph_e;
    mph_e         m_ph = M_IDLE;
    int           m_out = 0;
    logic [47:0]  m_hcnt = '0;
    logic         m_err = 1'b0, m_aborted = 1'b0, m_hit = 1'b0, m_abort = 1'b0;
    logic [31:0]  m_fn = '0, m_nonce = '0, m_limit = '0;
    logic [607:0] m_hdr = '0;
    logic [255:0] m_tgt = '0;

    int          cyc = 0;
    int          reads = 0, first_rd = -1, last_rd = -1, max_out = 0;
    logic [31:0] job_nonces[$];

    always @(negedge clk) begin
        logic        cw, co, pop, first_hit, exp_read, last;
        logic [31:0] rn;
        int          out_before;
        cyc++;
        if (!rst_n) begin
            core_write = 1'b0;
            core_out   = 1'b0;
            m_ph = M_IDLE; m_out = 0; m_hcnt = '0; m_err = 1'b0; m_aborted = 1'b0;
            m_hit = 1'b0; m_abort = 1'b0; m_fn = '0; m_nonce = '0; m_limit = '0;
            m_hdr = '0; m_tgt = '0;
        end else begin
            cw = 1'b0; co = 1'b0; rn = '0; last = 1'b0;
            if (inject_stray) begin
                cw = 1'b1;
            end else if (pipe.size() > 0 && pipe[0].due <= cyc) begin
                cw = 1'b1;
                rn = pipe[0].nonce;
                co = in_set(rn);
                void'(pipe.pop_front());
            end
            core_write = cw;
            core_out   = co;
            #1;
            check("busy", busy, m_ph == M_RUN || m_ph == M_DRAIN);
            check("found", found, m_ph == M_FOUND);
            check("done", done, m_ph == M_DONE);
            check("aborted", aborted, m_aborted);
            check("err", err, m_err);
            check("hash_count", hash_count, m_hcnt);
            check("core_target", core_target == m_tgt, 1'b1);
            if (m_ph == M_FOUND) check("found_nonce", found_nonce, m_fn);

            pop       = cw && m_out > 0;
            first_hit = pop && co && !m_hit && (m_ph == M_RUN || m_ph == M_DRAIN);
            exp_read  = (m_ph == M_RUN) && (m_out < MAXI || pop) && !first_hit;
            check("core_read", core_read, exp_read);
            if (core_read && exp_read) begin
                check("cand_nonce", core_in[31:0], m_nonce);
                check("cand_header", core_in[639:32] == m_hdr, 1'b1);
            end
            if (core_read) begin
                pipe.push_back('{core_in[31:0], cyc + lat});
                job_nonces.push_back(core_in[31:0]);
                reads++;
                if (first_rd < 0) first_rd = cyc;
                last_rd = cyc;
                if (pipe.size() > max_out) max_out = pipe.size();
            end
            check("outstanding_le_max", pipe.size() <= MAXI, 1'b1);

            out_before = m_out;
            if (cw && m_out == 0) m_err = 1'b1;
            if (pop) begin
                m_out--;
                if (m_hcnt != '1) m_hcnt++;
                if (first_hit) begin
                    m_hit = 1'b1;
                    m_fn  = rn;
                end
            end
            if (exp_read) begin
                m_out++;
                last = (m_nonce == m_limit);
                m_nonce++;
            end
            case (m_ph)
                M_IDLE, M_FOUND, M_DONE: if (start) begin
                    m_ph = M_RUN; m_hdr = header; m_tgt = target; m_nonce = nonce_base;
                    m_limit = nonce_limit; m_hcnt = '0; m_aborted = 1'b0; m_hit = 1'b0;
                    m_abort = 1'b0; m_fn = '0;
                    reads = 0; first_rd = -1; last_rd = -1; max_out = 0;
                    job_nonces.delete();
                end
                M_RUN: begin
                    if (stop && !first_hit) m_abort = 1'b1;
                    if (first_hit || stop || last) m_ph = M_DRAIN;
                end
                M_DRAIN: if (out_before == 0 && !cw) begin
                    if (m_hit) m_ph = M_FOUND;
                    else if (m_abort) begin
                        m_ph = M_IDLE;
                        m_aborted = 1'b1;
                    end else m_ph = M_DONE;
                end
                default: ;
            endcase
        end
    end

    task automatic run_job(input logic [31:0] b, input logic [31:0] l);
        @(posedge clk); #1;
        for (int i = 0; i < 19; i++) header[i*32 +: 32] = $urandom;
        for (int i = 0; i < 8; i++) target[i*32 +: 32] = $urandom;
        nonce_base  = b;
        nonce_limit = l;
        start       = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_end(input int bound);
        int n = 0;
        while (busy && n < bound) begin
            @(posedge clk); #1;
            n++;
        end
        check("job_ends_in_budget", busy, 1'b0);
    endtask

    initial begin
        bit hit20;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_core_in", core_in == '0, 1);
        check("rst_hash_count", hash_count, 0);
        check("rst_err", err, 0);
        rst_n = 1'b1;

        // 1: 0..99, no hits
        run_job(32'd0, 32'd99);
        wait_end(2000);
        check("t1_done", done, 1);
        check("t1_found", found, 0);
        check("t1_hash_count", hash_count, 100);
        check("t1_reads", reads, 100);
        check("t1_consecutive_span", last_rd - first_rd, 99);

        // 2: first hit at 0x42 wins; 0x50 never issued
        hit_set = '{32'h42, 32'h50};
        run_job(32'd0, 32'h0000_FFFF);
        wait_end(2000);
        check("t2_found", found, 1);
        check("t2_found_nonce", found_nonce, 32'h0000_0042);
        check("t2_hash_count", hash_count, 76);
        check("t2_reads", reads, 76);

        // 3: range wraps through zero
        hit_set.delete();
        run_job(32'hFFFF_FFFE, 32'h0000_0001);
        wait_end(2000);
        check("t3_reads", reads, 4);
        if (job_nonces.size() == 4) begin
            check("t3_n0", job_nonces[0], 32'hFFFF_FFFE);
            check("t3_n1", job_nonces[1], 32'hFFFF_FFFF);
            check("t3_n2", job_nonces[2], 32'h0000_0000);
            check("t3_n3", job_nonces[3], 32'h0000_0001);
        end
        check("t3_done", done, 1);

        // 4: latency beyond FIFO depth
        lat = 40;
        run_job(32'd0, 32'd999);
        wait_end(6000);
        check("t4_max_outstanding", max_out, 32);
        check("t4_hash_count", hash_count, 1000);
        check("t4_done", done, 1);

        // 5: stop while nonce 20 is presented, then restart
        lat = 10;
        run_job(32'd0, 32'd1000);
        hit20 = 0;
        for (int i = 0; i < 200 && !hit20; i++) begin
            if (core_in[31:0] == 32'd20) hit20 = 1;
            else begin
                @(posedge clk); #1;
            end
        end
        check("t5_reached_20", hit20, 1);
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        check("t5_no_issue_after_stop", core_read, 0);
        wait_end(2000);
        check("t5_aborted", aborted, 1);
        check("t5_done", done, 0);
        check("t5_hash_count", hash_count, 21);
        run_job(32'd5, 32'd7);
        check("t5_aborted_cleared", aborted, 0);
        wait_end(2000);
        check("t5_restart_first", job_nonces.size() > 0 ? job_nonces[0] : 32'hDEAD, 32'd5);
        check("t5_restart_count", hash_count, 3);

        // 6: stray result, then reset mid-job
        @(posedge clk); #1;
        inject_stray = 1'b1;
        @(posedge clk); #1;
        inject_stray = 1'b0;
        check("t6_err_stray", err, 1);
        run_job(32'd0, 32'd1000);
        repeat (25) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_busy", busy, 0);
        check("t6_async_core_read", core_read, 0);
        check("t6_async_core_in", core_in == '0, 1);
        check("t6_async_target", core_target == '0, 1);
        check("t6_async_count", hash_count, 0);
        check("t6_async_err", err, 0);
        check("t6_async_flags", {found, done, aborted}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 100 && pipe.size() > 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        check("t6_pipe_drained", pipe.size(), 0);
        check("t6_err_after_reset", err, 1);
        check("t6_idle", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
